// File: rtl/memory_access_unit.sv
// memory_access_unit: memory stage of the RAPID-X core.
// Handles LB/LH/LW/LBU/LHU/SB/SH/SW over a req/ack data bus, applies byte
// enables and load extension, and returns a registered writeback.
// Optional feature macro: RAPID_MAU_TIMEOUT_EN compiles in the bus-timeout
// counter; without it WAIT holds until ack and TIMEOUT is unused.

package rapid_pkg;
    parameter int XLEN = 32;

    typedef struct packed {
        logic            mem;
        logic            iop;
        logic [2:0]      fcs_opcode;
        logic [4:0]      rd;
        logic [XLEN-1:0] debug_instruction;
    } control_mem_s;
endpackage

module memory_access_unit
    import rapid_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_valid,
    input  control_mem_s    i_control_signal,
    input  logic [XLEN-1:0] i_addr,
    input  logic [XLEN-1:0] i_store_data,
    output logic            o_stall,
    output logic            o_wb_valid,
    output logic [4:0]      o_wb_rd,
    output logic [XLEN-1:0] o_wb_data,
    output logic            o_misaligned,
    output logic            o_access_fault,
    output logic            o_dmem_req,
    output logic            o_dmem_we,
    output logic [XLEN-1:0] o_dmem_addr,
    output logic [XLEN-1:0] o_dmem_wdata,
    output logic [3:0]      o_dmem_be,
    input  logic            i_dmem_ack,
    input  logic [XLEN-1:0] i_dmem_rdata
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_e;

    // funct3 values with no load/store meaning
    function automatic logic is_illegal(input logic [2:0] fcs);
        return (fcs == 3'b011) || (fcs == 3'b110) || (fcs == 3'b111);
    endfunction

    // fcs[1:0] encodes the access size: 00 byte, 01 half, 10 word
    function automatic logic is_misaligned(input logic [2:0] fcs, input logic [1:0] off);
        return ((fcs[1:0] == 2'b01) && off[0]) || ((fcs[1:0] == 2'b10) && (off != 2'b00));
    endfunction

    function automatic logic [3:0] byte_en(input logic [2:0] fcs, input logic [1:0] off);
        case (fcs[1:0])
            2'b00:   return 4'b0001 << off;
            2'b01:   return 4'b0011 << off;
            default: return 4'b1111;
        endcase
    endfunction

    // Replicate the store value across lanes so the bus only needs byte enables
    function automatic logic [XLEN-1:0] replicate(input logic [2:0] fcs, input logic [XLEN-1:0] d);
        case (fcs[1:0])
            2'b00:   return {4{d[7:0]}};
            2'b01:   return {2{d[15:0]}};
            default: return d;
        endcase
    endfunction

    // Shift the addressed lane down to bit 0, then sign or zero extend
    function automatic logic [XLEN-1:0] load_extend(input logic [2:0] fcs, input logic [1:0] off,
                                                    input logic [XLEN-1:0] rdata);
        logic [XLEN-1:0] lane;
        lane = rdata >> {off, 3'b000};
        case (fcs)
            3'b000:  return {{(XLEN-8){lane[7]}}, lane[7:0]};
            3'b001:  return {{(XLEN-16){lane[15]}}, lane[15:0]};
            3'b100:  return {{(XLEN-8){1'b0}}, lane[7:0]};
            3'b101:  return {{(XLEN-16){1'b0}}, lane[15:0]};
            default: return lane;
        endcase
    endfunction

    state_e          state_q, state_d;
    logic            stall_q, stall_d;
    logic            wb_valid_q, wb_valid_d;
    logic [4:0]      wb_rd_q, wb_rd_d;
    logic [XLEN-1:0] wb_data_q, wb_data_d;
    logic            mis_q, mis_d;
    logic            fault_q, fault_d;
    logic            req_q, req_d;
    logic            we_q, we_d;
    logic [XLEN-1:0] addr_q, addr_d;
    logic [XLEN-1:0] wdata_q, wdata_d;
    logic [3:0]      be_q, be_d;
    logic [2:0]      fcs_q, fcs_d;
    logic [4:0]      rd_q, rd_d;
    logic [1:0]      off_q, off_d;
`ifdef RAPID_MAU_TIMEOUT_EN
    logic [7:0]      cnt_q, cnt_d;
`else
    logic            unused_timeout;
    assign unused_timeout = (TIMEOUT != 0);
`endif

    logic unused_debug;
    assign unused_debug = ^i_control_signal.debug_instruction;

    // Next-state and next-output logic for the IDLE/WAIT/RESP sequence.
    // RESP already has its writeback registered, so it accepts a new
    // instruction exactly like IDLE; only WAIT stalls upstream.
    always_comb begin
        state_d    = state_q;
        stall_d    = stall_q;
        wb_valid_d = 1'b0;
        wb_rd_d    = wb_rd_q;
        wb_data_d  = wb_data_q;
        mis_d      = 1'b0;
        fault_d    = 1'b0;
        req_d      = req_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        be_d       = be_q;
        fcs_d      = fcs_q;
        rd_d       = rd_q;
        off_d      = off_q;
`ifdef RAPID_MAU_TIMEOUT_EN
        cnt_d      = cnt_q;
`endif
        case (state_q)
            IDLE, RESP: begin
                state_d = IDLE;
                stall_d = 1'b0;
                req_d   = 1'b0;
                if (i_valid) begin
                    if (!i_control_signal.mem) begin
                        wb_valid_d = (i_control_signal.rd != 5'd0);
                        wb_rd_d    = i_control_signal.rd;
                        wb_data_d  = i_addr;
                    end else if (is_illegal(i_control_signal.fcs_opcode)) begin
                        fault_d = 1'b1;
                    end else if (is_misaligned(i_control_signal.fcs_opcode, i_addr[1:0])) begin
                        mis_d = 1'b1;
                    end else begin
                        state_d = WAIT;
                        stall_d = 1'b1;
                        req_d   = 1'b1;
                        we_d    = i_control_signal.iop;
                        addr_d  = {i_addr[XLEN-1:2], 2'b00};
                        wdata_d = replicate(i_control_signal.fcs_opcode, i_store_data);
                        be_d    = byte_en(i_control_signal.fcs_opcode, i_addr[1:0]);
                        fcs_d   = i_control_signal.fcs_opcode;
                        rd_d    = i_control_signal.rd;
                        off_d   = i_addr[1:0];
`ifdef RAPID_MAU_TIMEOUT_EN
                        cnt_d   = 8'd0;
`endif
                    end
                end
            end
            WAIT: begin
                if (i_dmem_ack) begin
                    state_d = RESP;
                    stall_d = 1'b0;
                    req_d   = 1'b0;
                    if (!we_q) begin
                        wb_valid_d = (rd_q != 5'd0);
                        wb_rd_d    = rd_q;
                        wb_data_d  = load_extend(fcs_q, off_q, i_dmem_rdata);
                    end
`ifdef RAPID_MAU_TIMEOUT_EN
                end else if (cnt_q == 8'(TIMEOUT - 1)) begin
                    // This non-ack cycle is the TIMEOUT-th one: abandon the access
                    state_d = IDLE;
                    stall_d = 1'b0;
                    req_d   = 1'b0;
                    fault_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 8'd1;
`endif
                end
            end
            default: begin
                state_d = IDLE;
                stall_d = 1'b0;
                req_d   = 1'b0;
            end
        endcase
    end

    // State and registered outputs; reset clears everything, including a live request
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= IDLE;
            stall_q    <= 1'b0;
            wb_valid_q <= 1'b0;
            wb_rd_q    <= 5'd0;
            wb_data_q  <= '0;
            mis_q      <= 1'b0;
            fault_q    <= 1'b0;
            req_q      <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            be_q       <= 4'd0;
            fcs_q      <= 3'd0;
            rd_q       <= 5'd0;
            off_q      <= 2'd0;
`ifdef RAPID_MAU_TIMEOUT_EN
            cnt_q      <= 8'd0;
`endif
        end else begin
            state_q    <= state_d;
            stall_q    <= stall_d;
            wb_valid_q <= wb_valid_d;
            wb_rd_q    <= wb_rd_d;
            wb_data_q  <= wb_data_d;
            mis_q      <= mis_d;
            fault_q    <= fault_d;
            req_q      <= req_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            be_q       <= be_d;
            fcs_q      <= fcs_d;
            rd_q       <= rd_d;
            off_q      <= off_d;
`ifdef RAPID_MAU_TIMEOUT_EN
            cnt_q      <= cnt_d;
`endif
        end
    end

    assign o_stall        = stall_q;
    assign o_wb_valid     = wb_valid_q;
    assign o_wb_rd        = wb_rd_q;
    assign o_wb_data      = wb_data_q;
    assign o_misaligned   = mis_q;
    assign o_access_fault = fault_q;
    assign o_dmem_req     = req_q;
    assign o_dmem_we      = we_q;
    assign o_dmem_addr    = addr_q;
    assign o_dmem_wdata   = wdata_q;
    assign o_dmem_be      = be_q;

endmodule
